// File: rtl/seq_priority_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_priority_encoder_pkg
// Description : Shared definitions for the decoder/encoder family: default
//               index width, derived vector width, FSM state encoding and a
//               popcount helper sized to the vector width.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_priority_encoder_pkg;

  localparam int NE = 3;        // default index width
  localparam int W  = 2 ** NE;  // request vector width

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Number of set bits in a W-bit vector; NE+1 bits so a full vector fits.
  function automatic logic [NE:0] popcount(input logic [W-1:0] v);
    logic [NE:0] n;
    n = '0;
    for (int i = 0; i < W; i++) begin
      n = n + {{NE{1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_priority_encoder_lsb_index_find.sv
`default_nettype none
// ============================================================================
// Module      : lsb_index_find
// Description : Combinational lowest-set-bit finder.
//   vec     in  2**Ne  vector to search
//   idx     out Ne     index of lowest set bit (0 when vec is zero)
//   found   out 1      vec has at least one bit set
//   single  out 1      vec has exactly one bit set
// Revision    : 1.0 - initial release
// ============================================================================
module lsb_index_find #(
  parameter int Ne = 3
) (
  input  logic [2**Ne-1:0] vec,
  output logic [Ne-1:0]    idx,
  output logic             found,
  output logic             single
);

  always_comb begin
    idx = '0;
    // Scan from the top down so the lowest set bit is the last write.
    for (int i = 2**Ne - 1; i >= 0; i--) begin
      if (vec[i]) idx = Ne'(i);
    end
  end

  assign found  = |vec;
  // Clearing the lowest set bit leaves zero only if exactly one was set.
  assign single = found && ((vec & (vec - 1'b1)) == '0);

endmodule
`default_nettype wire

// File: rtl/seq_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : seq_priority_encoder
// Description : Captures a request vector via valid/ready, then emits one
//               index per accepted output beat, lowest set bit first.
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   req_valid  in  1      request vector valid
//   req_ready  out 1      block can accept a vector (IDLE)
//   req_vec    in  2**Ne  request vector
//   idx_valid  out 1      idx holds a valid index (SERVE)
//   idx_ready  in  1      consumer accepts idx
//   idx        out Ne     index of lowest pending bit
//   idx_last   out 1      idx is the final pending bit
//   req_count  out Ne+1   set bits in the last accepted vector
//   zero_req   out 1      one-cycle pulse after an all-zero vector accept
// Revision    : 1.0 - initial release
// ============================================================================
module seq_priority_encoder
  import seq_priority_encoder_pkg::*;
#(
  parameter int Ne = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2**Ne-1:0] req_vec,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [Ne-1:0]    idx,
  output logic             idx_last,
  output logic [Ne:0]      req_count,
  output logic             zero_req
);

  state_t            r_state, w_state_nxt;
  logic [2**Ne-1:0]  r_pending, w_pending_nxt;
  logic [Ne:0]       r_req_count, w_req_count_nxt;
  logic              r_zero_req, w_zero_req_nxt;

  logic [Ne-1:0]     w_lsb_idx;
  logic              w_found;
  logic              w_single;

  lsb_index_find #(.Ne(Ne)) u_lsb_index_find (
    .vec    (r_pending),
    .idx    (w_lsb_idx),
    .found  (w_found),
    .single (w_single)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_req_count <= '0;
      r_zero_req  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_req_count <= w_req_count_nxt;
      r_zero_req  <= w_zero_req_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pending_nxt   = r_pending;
    w_req_count_nxt = r_req_count;
    w_zero_req_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (req_vec != '0) begin
            w_pending_nxt   = req_vec;
            w_req_count_nxt = (Ne + 1)'(popcount(W'(req_vec)));
            w_state_nxt     = SERVE;
          end else begin
            w_req_count_nxt = '0;
            w_zero_req_nxt  = 1'b1;
          end
        end
      end
      SERVE: begin
        if (idx_ready) begin
          // Clear the bit being served: v & (v-1) drops the lowest set bit.
          w_pending_nxt = r_pending & (r_pending - 1'b1);
          if (w_single) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decode only from registered state; pending is zero in IDLE,
  // so idx naturally reads 0 there.
  assign req_ready = (r_state == IDLE);
  assign idx_valid = (r_state == SERVE);
  assign idx       = w_lsb_idx;
  assign idx_last  = (r_state == SERVE) && w_single;
  assign req_count = r_req_count;
  assign zero_req  = r_zero_req;

endmodule
`default_nettype wire

// File: tb/tb_seq_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_priority_encoder
// Description : Directed self-checking bench for seq_priority_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_priority_encoder;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_vec;
  logic       idx_valid;
  logic       idx_ready;
  logic [2:0] idx;
  logic       idx_last;
  logic [3:0] req_count;
  logic       zero_req;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  seq_priority_encoder #(.Ne(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx       (idx),
    .idx_last  (idx_last),
    .req_count (req_count),
    .zero_req  (zero_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept vector v, then serve the indices listed in exp_q.
  task automatic run_vec(input logic [7:0] v, input int cnt, input bit stall);
    req_valid = 1'b1;
    req_vec   = v;
    idx_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    req_vec   = 8'h3C;  // ignored while serving
    chk("cnt", 32'(req_count), 32'(cnt));
    chk("rdy_busy", 32'(req_ready), 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      chk("valid", 32'(idx_valid), 1);
      chk("idx", 32'(idx), 32'(exp_q[k]));
      chk("last", 32'(idx_last), 32'(k == exp_q.size() - 1));
      if (stall) begin
        idx_ready = 1'b0;
        tick();
        chk("hold_valid", 32'(idx_valid), 1);
        chk("hold_idx", 32'(idx), 32'(exp_q[k]));
        chk("hold_last", 32'(idx_last), 32'(k == exp_q.size() - 1));
        idx_ready = 1'b1;
      end
      tick();
    end
    chk("end_valid", 32'(idx_valid), 0);
    chk("end_rdy", 32'(req_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_vec   = 8'h00;
    idx_ready = 1'b0;
    tick();
    tick();
    chk("rst_rdy", 32'(req_ready), 1);
    chk("rst_valid", 32'(idx_valid), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_last", 32'(idx_last), 0);
    chk("rst_cnt", 32'(req_count), 0);
    chk("rst_zero", 32'(zero_req), 0);
    rst = 1'b0;
    tick();

    // Single bit 2
    exp_q = '{2};
    run_vec(8'b0000_0100, 1, 1'b0);

    // 0xA5 -> 0,2,5,7
    exp_q = '{0, 2, 5, 7};
    run_vec(8'hA5, 4, 1'b0);

    // 0xFF with stalls -> 0..7
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_vec(8'hFF, 8, 1'b1);

    // Single bit 7
    exp_q = '{7};
    run_vec(8'h80, 1, 1'b0);

    // All-zero vector
    req_valid = 1'b1;
    req_vec   = 8'h00;
    tick();
    req_valid = 1'b0;
    chk("zero_pulse", 32'(zero_req), 1);
    chk("zero_valid", 32'(idx_valid), 0);
    chk("zero_rdy", 32'(req_ready), 1);
    chk("zero_cnt", 32'(req_count), 0);
    tick();
    chk("zero_drop", 32'(zero_req), 0);
    chk("zero_valid2", 32'(idx_valid), 0);

    // 0xF0 interrupted by reset while idx=5 presented
    req_valid = 1'b1;
    req_vec   = 8'hF0;
    idx_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("f0_cnt", 32'(req_count), 4);
    chk("f0_idx0", 32'(idx), 4);
    tick();
    chk("f0_idx1", 32'(idx), 5);
    idx_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", 32'(idx_valid), 0);
    chk("rst2_rdy", 32'(req_ready), 1);
    chk("rst2_cnt", 32'(req_count), 0);
    chk("rst2_last", 32'(idx_last), 0);
    tick();
    chk("rst2_stay", 32'(idx_valid), 0);
    exp_q = '{0};
    run_vec(8'h01, 1, 1'b0);

    // Round trip through a 3-to-8 decoder model
    for (int i = 0; i < 8; i++) begin
      logic [7:0] dec;
      dec   = 8'h01 << i;
      exp_q = '{i};
      run_vec(dec, 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
